// File: rtl/branch_predictor.sv
// Purpose : fetch-stage branch predictor; direct-mapped BTB with 2-bit saturating
//           direction counters, trained from Decode, plus resolution/mispredict counters.
// Latency : lookup is combinational (zero cycles); training is visible the cycle after UpdateEn.
// Backpr. : none; one lookup and one update are accepted every cycle without stalling.
// Ports   : clk/reset (sync, active-high); LookupEn/PCF -> PredictionF/TargetF (fetch lookup);
//           UpdateEn/PCD/BranchTakenD/PCBranchD/PredictedD (decode training);
//           LookupCount/MispredictCount (wrapping performance counters).
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int CNTW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            LookupEn,
   input  logic [31:0]     PCF,
   output logic            PredictionF,
   output logic [31:0]     TargetF,
   input  logic            UpdateEn,
   input  logic [31:0]     PCD,
   input  logic            BranchTakenD,
   input  logic [31:0]     PCBranchD,
   input  logic            PredictedD,
   output logic [CNTW-1:0] LookupCount,
   output logic [CNTW-1:0] MispredictCount
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDXW;

   // Flop-based storage so valid/ctr can be cleared in one reset cycle.
   logic            valid_q  [ENTRIES];
   logic [1:0]      ctr_q    [ENTRIES];
   logic [TAGW-1:0] tag_q    [ENTRIES];
   logic [31:0]     target_q [ENTRIES];

   // Byte-offset bits of both PCs never participate in index or tag.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{PCF[1:0], PCD[1:0]};

   // ---------------- Lookup (fetch) ----------------
   logic [IDXW-1:0] lk_idx;
   logic [TAGW-1:0] lk_tag;
   logic            lk_hit;

   assign lk_idx = PCF[IDXW+1:2];
   assign lk_tag = PCF[31:IDXW+2];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   // Gated by reset so outputs read as empty during the reset cycle itself,
   // before the cleared valid bits have landed.
   assign PredictionF = !reset && LookupEn && lk_hit && ctr_q[lk_idx][1];
   assign TargetF     = (!reset && lk_hit) ? target_q[lk_idx] : 32'd0;

   // ---------------- Update (decode) ----------------
   logic [IDXW-1:0] up_idx;
   logic [TAGW-1:0] up_tag;
   logic            up_hit;
   logic            up_alloc;
   logic            up_target_wr;

   assign up_idx       = PCD[IDXW+1:2];
   assign up_tag       = PCD[31:IDXW+2];
   assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_alloc     = !up_hit && BranchTakenD;
   // Taken branches always (re)write the target, whether hitting or allocating.
   assign up_target_wr = !reset && UpdateEn && BranchTakenD;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
         LookupCount     <= '0;
         MispredictCount <= '0;
      end else if (UpdateEn) begin
         LookupCount <= LookupCount + CNTW'(1);
         if (PredictedD != BranchTakenD)
            MispredictCount <= MispredictCount + CNTW'(1);

         if (up_hit) begin
            if (BranchTakenD) begin
               if (ctr_q[up_idx] != 2'b11)
                  ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
            end else begin
               if (ctr_q[up_idx] != 2'b00)
                  ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
            end
         end else if (up_alloc) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target payload carries no reset; valid_q guards its contents.
   always_ff @(posedge clk) begin
      if (up_target_wr) begin
         target_q[up_idx] <= PCBranchD;
         if (up_alloc)
            tag_q[up_idx] <= up_tag;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Purpose : directed self-checking bench for branch_predictor (ENTRIES=64, CNTW=4).
// Latency : lookups checked combinationally; updates checked one cycle later.
// Backpr. : not applicable; stimulus is cycle-driven with fixed cycle counts.
module tb_branch_predictor;

   localparam int CNTW = 4;

   logic            clk;
   logic            reset;
   logic            LookupEn;
   logic [31:0]     PCF;
   logic            PredictionF;
   logic [31:0]     TargetF;
   logic            UpdateEn;
   logic [31:0]     PCD;
   logic            BranchTakenD;
   logic [31:0]     PCBranchD;
   logic            PredictedD;
   logic [CNTW-1:0] LookupCount;
   logic [CNTW-1:0] MispredictCount;

   int tests_run;
   int tests_failed;

   branch_predictor #(.ENTRIES(64), .CNTW(CNTW)) dut (
      .clk             (clk),
      .reset           (reset),
      .LookupEn        (LookupEn),
      .PCF             (PCF),
      .PredictionF     (PredictionF),
      .TargetF         (TargetF),
      .UpdateEn        (UpdateEn),
      .PCD             (PCD),
      .BranchTakenD    (BranchTakenD),
      .PCBranchD       (PCBranchD),
      .PredictedD      (PredictedD),
      .LookupCount     (LookupCount),
      .MispredictCount (MispredictCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; checks happen 1ns later still.
   task automatic upd(input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt, input logic pred);
      UpdateEn     = 1'b1;
      PCD          = pc;
      BranchTakenD = taken;
      PCBranchD    = tgt;
      PredictedD   = pred;
      @(posedge clk);
      #1;
      UpdateEn = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, input logic en);
      LookupEn = en;
      PCF      = pc;
      #1;
   endtask

   task automatic check_lookup(input string tag, input logic [31:0] pc,
                               input logic exp_pred, input logic [31:0] exp_tgt);
      look(pc, 1'b1);
      check_val({tag, ".pred"}, {31'd0, PredictionF}, {31'd0, exp_pred});
      check_val({tag, ".tgt"},  TargetF, exp_tgt);
   endtask

   task automatic check_counts(input string tag, input int lc, input int mc);
      check_val({tag, ".lookups"},    {{(32-CNTW){1'b0}}, LookupCount},     lc);
      check_val({tag, ".mispredict"}, {{(32-CNTW){1'b0}}, MispredictCount}, mc);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      LookupEn     = 1'b0;
      PCF          = 32'd0;
      UpdateEn     = 1'b0;
      PCD          = 32'd0;
      BranchTakenD = 1'b0;
      PCBranchD    = 32'd0;
      PredictedD   = 1'b0;

      // 1: reset state
      @(posedge clk); #1;
      check_lookup("in_reset", 32'h100, 1'b0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      check_lookup("post_reset", 32'h100, 1'b0, 32'h0);
      check_counts("post_reset", 0, 0);

      // 2: first taken branch allocates with ctr=10
      upd(32'h100, 1'b1, 32'h200, 1'b0);
      check_lookup("alloc", 32'h100, 1'b1, 32'h200);
      check_counts("alloc", 1, 1);

      // 3: counter walk 10->11(sat)->10->01->00(sat)->01
      for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 32'h200, 1'b1);
      check_lookup("strong_t", 32'h100, 1'b1, 32'h200);
      check_counts("strong_t", 4, 1);
      upd(32'h100, 1'b0, 32'h0, 1'b1);
      check_lookup("weak_t", 32'h100, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 32'h0, 1'b1);
      upd(32'h100, 1'b0, 32'h0, 1'b0);
      check_lookup("strong_nt", 32'h100, 1'b0, 32'h200);
      check_counts("strong_nt", 7, 3);
      upd(32'h100, 1'b0, 32'h0, 1'b0);
      upd(32'h100, 1'b1, 32'h240, 1'b0);
      check_lookup("nt_sat", 32'h100, 1'b0, 32'h240);
      check_counts("nt_sat", 9, 4);

      // 4: index conflict, 0x200 evicts 0x100 (both index 0)
      upd(32'h200, 1'b1, 32'h300, 1'b0);
      check_lookup("evicted", 32'h100, 1'b0, 32'h0);
      check_lookup("evictor", 32'h200, 1'b1, 32'h300);
      look(32'h200, 1'b0);
      check_val("lookup_dis.pred", {31'd0, PredictionF}, 32'd0);
      check_val("lookup_dis.tgt",  TargetF, 32'h300);
      check_counts("evict", 10, 5);

      // 5: not-taken miss does not allocate
      upd(32'h404, 1'b0, 32'h999, 1'b1);
      check_lookup("no_alloc", 32'h404, 1'b0, 32'h0);

      // 5b: concurrent lookup/update on the same entry sees pre-update state
      look(32'h200, 1'b1);
      UpdateEn = 1'b1; PCD = 32'h200; BranchTakenD = 1'b0; PCBranchD = 32'h0; PredictedD = 1'b1;
      #1;
      check_val("conc_nt_pre.pred", {31'd0, PredictionF}, 32'd1);
      @(posedge clk); #1;
      UpdateEn = 1'b0; #1;
      check_val("conc_nt_post.pred", {31'd0, PredictionF}, 32'd0);
      check_val("conc_nt_post.tgt",  TargetF, 32'h300);
      UpdateEn = 1'b1; PCD = 32'h200; BranchTakenD = 1'b1; PCBranchD = 32'h340; PredictedD = 1'b0;
      #1;
      check_val("conc_t_pre.pred", {31'd0, PredictionF}, 32'd0);
      check_val("conc_t_pre.tgt",  TargetF, 32'h300);
      @(posedge clk); #1;
      UpdateEn = 1'b0; #1;
      check_val("conc_t_post.pred", {31'd0, PredictionF}, 32'd1);
      check_val("conc_t_post.tgt",  TargetF, 32'h340);
      check_counts("conc", 13, 8);

      // 6: reset wins over a same-cycle update
      reset = 1'b1;
      UpdateEn = 1'b1; PCD = 32'h100; BranchTakenD = 1'b1; PCBranchD = 32'h500; PredictedD = 1'b0;
      look(32'h200, 1'b1);
      check_val("rst_cycle.pred", {31'd0, PredictionF}, 32'd0);
      check_val("rst_cycle.tgt",  TargetF, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; UpdateEn = 1'b0;
      check_lookup("rst_drop", 32'h100, 1'b0, 32'h0);
      check_lookup("rst_clear", 32'h200, 1'b0, 32'h0);
      check_counts("rst", 0, 0);

      // 6b: 4-bit counters wrap after 16 updates
      for (int i = 0; i < 15; i++) upd(32'h404, 1'b0, 32'h0, 1'b1);
      check_counts("pre_wrap", 15, 15);
      upd(32'h404, 1'b0, 32'h0, 1'b1);
      check_counts("wrap", 0, 0);
      check_lookup("wrap_no_alloc", 32'h404, 1'b0, 32'h0);

      // Idle cycles leave state unchanged
      repeat (3) @(posedge clk);
      #1;
      check_counts("idle", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
